// File: rtl/btn_debounce_pulser.sv
// btn_debounce_pulser: synchronises and debounces a push-button, emitting registered
// press/release pulses and an optional hold-to-auto-repeat press pulse train.
module btn_debounce_pulser #(
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter bit ACTIVE_LOW           = 1,
  parameter bit REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press_pulse,
  output logic btn_release_pulse,
  output logic btn_repeat_active
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW   = $clog2(RMAX) + 1;
  localparam logic [CW-1:0] C_LAST   = CW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [RW-1:0] rcnt;
  logic s;
  logic cnt_done;
  logic rep_hit;
  assign s        = sync[1] ^ ACTIVE_LOW;
  assign cnt_inc  = cnt + 1'b1;
  assign cnt_done = cnt_inc == C_LAST;
  // btn_repeat_active doubles as the delay/period phase of the repeat counter
  assign rep_hit  = REPEAT_EN && (rcnt == (btn_repeat_active ? R_PERIOD : R_DELAY));
  always_ff @(posedge clk or negedge async_nreset)
    if (!async_nreset) begin
      sync              <= {2{ACTIVE_LOW}};
      state             <= RELEASED;
      cnt               <= '0;
      rcnt              <= '0;
      btn_level         <= 1'b0;
      btn_press_pulse   <= 1'b0;
      btn_release_pulse <= 1'b0;
      btn_repeat_active <= 1'b0;
    end else begin
      sync              <= {sync[0], btn_raw};
      btn_press_pulse   <= 1'b0;
      btn_release_pulse <= 1'b0;
      case (state)
        RELEASED, PRESS_CHECK:
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt_done) begin
            state           <= PRESSED;
            cnt             <= '0;
            rcnt            <= '0;
            btn_level       <= 1'b1;
            btn_press_pulse <= 1'b1;
          end else begin
            state <= PRESS_CHECK;
            cnt   <= cnt_inc;
          end
        PRESSED:
          if (!s && cnt_done) begin
            state             <= RELEASED;
            cnt               <= '0;
            rcnt              <= '0;
            btn_level         <= 1'b0;
            btn_release_pulse <= 1'b1;
            btn_repeat_active <= 1'b0;
          end else begin
            if (!s) begin
              state <= RELEASE_CHECK;
              cnt   <= cnt_inc;
            end
            if (REPEAT_EN) begin
              rcnt <= rep_hit ? '0 : rcnt + 1'b1;
              if (rep_hit) begin
                btn_press_pulse   <= 1'b1;
                btn_repeat_active <= 1'b1;
              end
            end
          end
        RELEASE_CHECK:
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_done) begin
            state             <= RELEASED;
            cnt               <= '0;
            rcnt              <= '0;
            btn_level         <= 1'b0;
            btn_release_pulse <= 1'b1;
            btn_repeat_active <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
          rcnt  <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_btn_debounce_pulser.sv
// tb_btn_debounce_pulser: directed checks of debounce timing, bounce rejection,
// auto-repeat scheduling and reset behaviour on three parameterisations.
module tb_btn_debounce_pulser;
  logic clk = 1'b0;
  logic async_nreset = 1'b0;
  logic raw0 = 1'b1;
  logic raw1 = 1'b1;
  logic raw2 = 1'b0;
  logic lv0, pp0, rp0, ra0;
  logic lv1, pp1, rp1, ra1;
  logic lv2, pp2, rp2, ra2;
  int checks = 0;
  int errors = 0;
  int np0 = 0, nr0 = 0, led0 = 0;
  int ov = 0, lng = 0, alt = 0;
  logic ppd0 = 1'b0, rpd0 = 1'b0, ppd1 = 1'b0, rpd1 = 1'b0;
  logic last0 = 1'b0;
  logic [4:0] bounce = 5'b01101;

  btn_debounce_pulser #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(0)) u0 (
    .clk(clk), .async_nreset(async_nreset), .btn_raw(raw0), .btn_level(lv0),
    .btn_press_pulse(pp0), .btn_release_pulse(rp0), .btn_repeat_active(ra0));
  btn_debounce_pulser #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(5)) u1 (
    .clk(clk), .async_nreset(async_nreset), .btn_raw(raw1), .btn_level(lv1),
    .btn_press_pulse(pp1), .btn_release_pulse(rp1), .btn_repeat_active(ra1));
  btn_debounce_pulser #(.DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0), .REPEAT_EN(0)) u2 (
    .clk(clk), .async_nreset(async_nreset), .btn_raw(raw2), .btn_level(lv2),
    .btn_press_pulse(pp2), .btn_release_pulse(rp2), .btn_repeat_active(ra2));

  always #5 clk = ~clk;

  // pulse bookkeeping and the downstream LED stepper model (mod-10 counter)
  always @(negedge clk) begin
    if (pp0) begin
      np0 = np0 + 1;
      led0 = (led0 == 9) ? 0 : led0 + 1;
      if (last0) alt = alt + 1;
      last0 = 1'b1;
    end
    if (rp0) begin
      nr0 = nr0 + 1;
      if (!last0) alt = alt + 1;
      last0 = 1'b0;
    end
    if ((pp0 && rp0) || (pp1 && rp1) || (pp2 && rp2)) ov = ov + 1;
    if ((pp0 && ppd0) || (rp0 && rpd0) || (pp1 && ppd1) || (rp1 && rpd1)) lng = lng + 1;
    ppd0 = pp0; rpd0 = rp0; ppd1 = pp1; rpd1 = rp1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    int bp, br;
    #12 async_nreset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_outputs", |{lv0, pp0, rp0, ra0, lv1, pp1, rp1, ra1, lv2, pp2, rp2, ra2}, 1'b0);
    end
    // clean press: pulse between edges 6 and 7
    raw0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("clean_press_pulse", pp0, i == 6);
      chk("clean_press_level", lv0, i >= 6);
    end
    raw0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("clean_release_pulse", rp0, i == 6);
      chk("clean_release_level", lv0, i < 6);
    end
    chkn("clean_press_count", np0, 1);
    chkn("clean_release_count", nr0, 1);
    // bouncing press then bouncing release: acceptance at edge 11
    for (int i = 1; i <= 13; i++) begin
      raw0 = (i <= 5) ? ~bounce[i-1] : 1'b0;
      tick();
      chk("bounce_press_pulse", pp0, i == 11);
      chk("bounce_press_level", lv0, i >= 11);
    end
    for (int i = 1; i <= 13; i++) begin
      raw0 = (i <= 5) ? bounce[i-1] : 1'b1;
      tick();
      chk("bounce_release_pulse", rp0, i == 11);
      chk("bounce_release_level", lv0, i < 11);
    end
    chkn("bounce_press_count", np0, 2);
    chkn("bounce_release_count", nr0, 2);
    // ten clean presses drive the stepper from 2 round through 9 and back to 2
    bp = np0;
    br = nr0;
    for (int k = 0; k < 10; k++) begin
      raw0 = 1'b0;
      repeat (8) tick();
      chkn("led_step", led0, (k + 3) % 10);
      chk("norepeat_active", ra0, 1'b0);
      raw0 = 1'b1;
      repeat (8) tick();
    end
    chkn("ten_press_count", np0 - bp, 10);
    chkn("ten_release_count", nr0 - br, 10);
    // auto-repeat: accept at 6, repeats at 16,21,26,31, release accepted at 38
    for (int i = 1; i <= 60; i++) begin
      raw1 = (i <= 32) ? 1'b0 : 1'b1;
      tick();
      chk("repeat_pulse", pp1, i == 6 || i == 16 || i == 21 || i == 26 || i == 31);
      chk("repeat_release", rp1, i == 38);
      chk("repeat_active", ra1, i >= 16 && i <= 37);
      chk("repeat_level", lv1, i >= 6 && i <= 37);
    end
    // 2-sample release glitch while held shifts the schedule by 2 cycles
    for (int i = 1; i <= 30; i++) begin
      raw1 = (i == 8 || i == 9) ? 1'b1 : 1'b0;
      tick();
      chk("glitch_pulse", pp1, i == 6 || i == 18 || i == 23 || i == 28);
      chk("glitch_release", rp1, 1'b0);
      chk("glitch_active", ra1, i >= 18);
      chk("glitch_level", lv1, i >= 6);
    end
    raw1 = 1'b1;
    repeat (10) tick();
    chk("glitch_end_level", lv1, 1'b0);
    chk("glitch_end_active", ra1, 1'b0);
    // single-sample debounce, active-high pin
    raw2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("d1_press_pulse", pp2, i == 3);
      chk("d1_press_level", lv2, i >= 3);
    end
    raw2 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("d1_release_pulse", rp2, i == 3);
      chk("d1_release_level", lv2, i < 3);
    end
    chkn("pulse_overlap", ov, 0);
    chkn("pulse_too_long", lng, 0);
    chkn("press_release_alternation", alt, 0);
    // asynchronous reset mid-cycle clears outputs before the next edge
    raw0 = 1'b0;
    repeat (8) tick();
    chk("pre_reset_level", lv0, 1'b1);
    #2 async_nreset = 1'b0;
    #1;
    chk("async_reset_level", lv0, 1'b0);
    chk("async_reset_outputs", |{lv0, pp0, rp0, ra0, lv1, pp1, rp1, ra1, lv2, pp2, rp2, ra2}, 1'b0);
    #3 async_nreset = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_debounce_pulser.md
Name: btn_debounce_pulser

Overview:
Front-end conditioning stage for board push-buttons. It synchronises a raw, bouncing button input to clk and debounces it with a consecutive-sample counter. It emits single-cycle press/release pulses plus an optional hold-to-auto-repeat pulse train. btn_press_pulse drives btn_next_led_debounded of the LED state stepper directly downstream; each pulse advances that stepper by exactly one state.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a press or release (10 ms at 50 MHz); legal range >= 1
ACTIVE_LOW, 1, 1: raw pin reads 0 when pressed; 0: reads 1 when pressed
REPEAT_EN, 0, 1 enables auto-repeat press pulses while held
REPEAT_DELAY_CYCLES, 25000000, cycles from the accepted press pulse to the first repeat pulse; legal range >= 2
REPEAT_PERIOD_CYCLES, 10000000, cycles between successive repeat pulses; legal range >= 2

Ports:
clk  input  1  system clock
async_nreset  input  1  reset, asynchronous, active-low
btn_raw  input  1  raw asynchronous button pin
btn_level  output  1  debounced level, 1 = pressed
btn_press_pulse  output  1  one-cycle pulse on each accepted press and each repeat
btn_release_pulse  output  1  one-cycle pulse on accepted release
btn_repeat_active  output  1  high from the first repeat pulse until the release is accepted

Behaviour:
- Reset (async, active-low): sync flops load the inactive pin level. FSM goes to RELEASED and all counters clear. All outputs are 0. Reset mid-debounce or mid-repeat aborts with no pulse.
- Synchroniser: two flops. The value is normalised to s (1 = pressed) after the second flop. If btn_raw changes before edge 1, s is active after edge 2.
- FSM states: RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK.
- RELEASED with s=1: go to PRESS_CHECK and set cnt=1.
- PRESS_CHECK:
  - s=0: return to RELEASED, cnt=0, no output.
  - s=1 and cnt==DEBOUNCE_CYCLES: go to PRESSED and register btn_press_pulse=1 for one cycle. btn_level=1 from the same edge.
  - Otherwise cnt++.
  - DEBOUNCE_CYCLES=1 accepts on the first sample.
- PRESSED with s=0: go to RELEASE_CHECK, cnt=1.
- RELEASE_CHECK:
  - s=1: return to PRESSED, no output.
  - s=0 and cnt==DEBOUNCE_CYCLES: go to RELEASED, pulse btn_release_pulse for one cycle, btn_level=0, btn_repeat_active=0.
  - Otherwise cnt++.
- Timing: sample k of a stable level is taken at edge k+2 after a raw change before edge 1. The accept pulse is high between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
- Pulse properties:
  - Pulses are registered and never combinational.
  - btn_press_pulse and btn_release_pulse are never high in the same cycle.
  - Pulses are never longer than one cycle.
  - There is never more than one press pulse per accepted press when REPEAT_EN=0.
- Auto-repeat (REPEAT_EN=1):
  - rcnt starts at 0 on press acceptance and increments each cycle in PRESSED.
  - rcnt==REPEAT_DELAY_CYCLES-1: press pulse, btn_repeat_active=1, rcnt=0, phase switches to period.
  - Thereafter rcnt==REPEAT_PERIOD_CYCLES-1: press pulse, rcnt=0.
  - In RELEASE_CHECK, rcnt freezes. An aborted release resumes from the frozen value. An accepted release clears rcnt and phase.
  - With REPEAT_EN=0, the repeat logic is inert and btn_repeat_active stays 0.
- Counter widths: each counter is sized by $clog2 of its parameter + 1. No counter wraps, because every counter is cleared on its terminal value or on a state change.
- Bounce shorter than DEBOUNCE_CYCLES samples never changes btn_level and never produces a pulse.

Test Plan:
- Reset then idle with btn_raw at the inactive level for 100 cycles -> all outputs 0 throughout; reassert async_nreset mid-cycle -> outputs 0 immediately.
- DEBOUNCE_CYCLES=4, clean press before edge 1 -> btn_press_pulse high only between edges 6 and 7; btn_level=1 from edge 6; exactly one pulse.
- DEBOUNCE_CYCLES=4, press bouncing 1,0,1,1,0 samples then stable -> no pulse until 4 consecutive active samples; exactly one press pulse; same bounce on release -> one release pulse.
- Ten clean press/release cycles -> exactly 10 press and 10 release pulses, alternating, never overlapping; the downstream LED stepper counts 0..9 then wraps to 0.
- REPEAT_EN=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5, hold for 30 cycles past acceptance -> pulses at acceptance, +10, +15, +20, +25; btn_repeat_active=1 from +10; after release is accepted it is 0 with no further pulses.
- REPEAT_EN=1, 2-sample release glitch during hold -> state returns to PRESSED, no release pulse; repeat schedule shifts by 2 cycles (rcnt frozen).
